neuron_tdm_scheduler: RTL and testbench

- Time-multiplexes one shared, stateless neuron-update datapath across N_NEURONS neurons.
- The datapath is the combinational FitzHugh-Nagumo-style Euler step in Q3.12: (v, w, i) -> (v_next, w_next).
- The block holds per-neuron v/w state and input currents, and sequences the datapath for a host-requested number of timesteps.
- It emits spike events on threshold up-crossings and signals completion to the host.

---
 rtl/neuron_tdm_scheduler_if.sv | 42 ++++
 rtl/neuron_tdm_scheduler.sv | 151 +++++++++++++++
 tb/tb_neuron_tdm_scheduler.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_tdm_scheduler_if.sv
// Host, datapath and spike signals of the neuron TDM scheduler.
// The master side is the host plus the external update datapath; the scheduler is the slave.
interface neuron_tdm_scheduler_if #(
  parameter int IDX_W   = 4,
  parameter int W       = 16,
  parameter int STEPS_W = 16
);
  logic               start;
  logic               clear;
  logic [STEPS_W-1:0] num_steps;
  logic               i_we;
  logic [IDX_W-1:0]   i_addr;
  logic [W-1:0]       i_data;
  logic               busy;
  logic               done;
  logic               dp_valid;
  logic [W-1:0]       dp_v;
  logic [W-1:0]       dp_w;
  logic [W-1:0]       dp_i;
  logic [W-1:0]       dp_v_next;
  logic [W-1:0]       dp_w_next;
  logic               spike_valid;
  logic [IDX_W-1:0]   spike_idx;
  logic [STEPS_W-1:0] spike_step;
  logic [IDX_W-1:0]   rd_addr;
  logic [W-1:0]       rd_v;
  logic [W-1:0]       rd_w;

  modport master (
    output start, clear, num_steps, i_we, i_addr, i_data,
    output dp_v_next, dp_w_next, rd_addr,
    input  busy, done, dp_valid, dp_v, dp_w, dp_i,
    input  spike_valid, spike_idx, spike_step, rd_v, rd_w
  );

  modport slave (
    input  start, clear, num_steps, i_we, i_addr, i_data,
    input  dp_v_next, dp_w_next, rd_addr,
    output busy, done, dp_valid, dp_v, dp_w, dp_i,
    output spike_valid, spike_idx, spike_step, rd_v, rd_w
  );
endinterface

// File: rtl/neuron_tdm_scheduler.sv
// Time-multiplexes one external combinational neuron-update datapath over N_NEURONS
// neurons, holding per-neuron v/w/current state and emitting threshold up-crossing spikes.
module neuron_tdm_scheduler #(
  parameter int                   N_NEURONS = 16,
  parameter int                   IDX_W     = 4,
  parameter int                   W         = 16,
  parameter int                   STEPS_W   = 16,
  parameter logic signed [W-1:0]  SPIKE_TH  = 16'sd4096,
  parameter logic [W-1:0]         V_INIT    = 16'hECE1,
  parameter logic [W-1:0]         W_INIT    = 16'hF600
) (
  input logic                   clk,
  input logic                   rst,
  neuron_tdm_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ISSUE,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(N_NEURONS - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);
  localparam logic [STEPS_W-1:0] STEP_ONE = STEPS_W'(1);

  state_t             state, state_nx;
  logic [IDX_W-1:0]   idx, idx_nx;
  logic [STEPS_W-1:0] step, step_nx;
  logic [STEPS_W-1:0] steps_q, steps_nx;

  logic [W-1:0] v_mem [N_NEURONS];
  logic [W-1:0] w_mem [N_NEURONS];
  logic [W-1:0] i_mem [N_NEURONS];

  logic spike_hit;

  // Up-crossing: the operand v was below threshold and the result reaches it.
  assign spike_hit = ($signed(bus.dp_v) < SPIKE_TH) && ($signed(bus.dp_v_next) >= SPIKE_TH);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    step_nx  = step;
    steps_nx = steps_q;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          steps_nx = bus.num_steps;
          idx_nx   = '0;
          step_nx  = '0;
          if (bus.clear)                state_nx = S_INIT;
          else if (bus.num_steps == '0) state_nx = S_DONE;
          else                          state_nx = S_ISSUE;
        end
      end
      S_INIT: begin
        if (idx == IDX_LAST) begin
          idx_nx   = '0;
          state_nx = (steps_q == '0) ? S_DONE : S_ISSUE;
        end else begin
          idx_nx = idx + IDX_ONE;
        end
      end
      S_ISSUE: state_nx = S_CAPTURE;
      S_CAPTURE: begin
        if (idx != IDX_LAST) begin
          idx_nx   = idx + IDX_ONE;
          state_nx = S_ISSUE;
        end else if (step < steps_q - STEP_ONE) begin
          idx_nx   = '0;
          step_nx  = step + STEP_ONE;
          state_nx = S_ISSUE;
        end else begin
          state_nx = S_DONE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      step    <= '0;
      steps_q <= '0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      step    <= step_nx;
      steps_q <= steps_nx;
    end
  end

  // NOTE: the state tables are flops, not RAM, because every entry must clear on reset and be readable combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        v_mem[k] <= V_INIT;
        w_mem[k] <= W_INIT;
        i_mem[k] <= '0;
      end
      bus.dp_valid    <= 1'b0;
      bus.dp_v        <= '0;
      bus.dp_w        <= '0;
      bus.dp_i        <= '0;
      bus.spike_valid <= 1'b0;
      bus.spike_idx   <= '0;
      bus.spike_step  <= '0;
    end else begin
      bus.dp_valid    <= (state == S_ISSUE);
      bus.spike_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.i_we) i_mem[bus.i_addr] <= bus.i_data;
        end
        S_INIT: begin
          v_mem[idx] <= V_INIT;
          w_mem[idx] <= W_INIT;
        end
        S_ISSUE: begin
          bus.dp_v <= v_mem[idx];
          bus.dp_w <= w_mem[idx];
          bus.dp_i <= i_mem[idx];
        end
        S_CAPTURE: begin
          v_mem[idx] <= bus.dp_v_next;
          w_mem[idx] <= bus.dp_w_next;
          if (spike_hit) begin
            bus.spike_valid <= 1'b1;
            bus.spike_idx   <= idx;
            bus.spike_step  <= step;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != S_IDLE);
  assign bus.done = (state == S_DONE);
  assign bus.rd_v = v_mem[bus.rd_addr];
  assign bus.rd_w = w_mem[bus.rd_addr];

endmodule

// File: tb/tb_neuron_tdm_scheduler.sv
// Directed bench for neuron_tdm_scheduler with N=4 and a mock datapath
// (v_next = v + i, w_next = w); expected values are hand-computed constants.
module tb_neuron_tdm_scheduler;

  localparam int N = 4;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  // Shadow of the per-neuron v and current values, used for operand-order checks.
  logic [15:0] mv [N];
  logic [15:0] mi [N];

  int run_cycles, run_valid, done_at, done_cnt;
  int spk_n, spk_idx, spk_step;

  neuron_tdm_scheduler_if #(.IDX_W(2), .W(16), .STEPS_W(16)) bus ();

  neuron_tdm_scheduler #(
    .N_NEURONS(N),
    .IDX_W    (2),
    .W        (16),
    .STEPS_W  (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  assign bus.dp_v_next = bus.dp_v + bus.dp_i;
  assign bus.dp_w_next = bus.dp_w;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rd(input string tag, input int a, input logic [15:0] ev, input logic [15:0] ew);
    bus.rd_addr = a[1:0];
    #1;
    check($sformatf("%s_v%0d", tag, a), {16'h0, bus.rd_v}, {16'h0, ev});
    check($sformatf("%s_w%0d", tag, a), {16'h0, bus.rd_w}, {16'h0, ew});
  endtask

  task automatic write_i(input int a, input logic [15:0] d);
    bus.i_we   = 1'b1;
    bus.i_addr = a[1:0];
    bus.i_data = d;
    tick();
    bus.i_we   = 1'b0;
    mi[a]      = d;
  endtask

  // Starts a run and follows it until busy drops, checking each operand
  // pair against the shadow state in the expected 0..N-1 order.
  task automatic run(input int steps, input bit clr, input bit poke);
    int k;
    if (clr) for (int j = 0; j < N; j++) mv[j] = 16'hECE1;
    bus.start     = 1'b1;
    bus.clear     = clr;
    bus.num_steps = steps[15:0];
    tick();
    bus.start     = 1'b0;
    bus.clear     = 1'b0;
    bus.num_steps = 16'hFFFF;
    run_cycles = 0;
    run_valid  = 0;
    done_at    = 0;
    done_cnt   = 0;
    spk_n      = 0;
    while (bus.busy && run_cycles < 2000) begin
      run_cycles++;
      if (bus.done) begin
        done_at = run_cycles;
        done_cnt++;
      end
      if (bus.dp_valid) begin
        k = run_valid % N;
        check("dp_v_order", {16'h0, bus.dp_v}, {16'h0, mv[k]});
        check("dp_i_order", {16'h0, bus.dp_i}, {16'h0, mi[k]});
        mv[k] = mv[k] + mi[k];
        run_valid++;
      end
      if (bus.spike_valid) begin
        spk_n++;
        spk_idx  = int'(bus.spike_idx);
        spk_step = int'(bus.spike_step);
      end
      if (poke && run_cycles == 5) begin
        bus.start  = 1'b1;
        bus.i_we   = 1'b1;
        bus.i_addr = 2'd2;
        bus.i_data = 16'h0200;
      end else begin
        bus.start = 1'b0;
        bus.i_we  = 1'b0;
      end
      tick();
    end
    bus.start = 1'b0;
    bus.i_we  = 1'b0;
  endtask

  initial begin
    int nv;
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.clear     = 1'b0;
    bus.num_steps = '0;
    bus.i_we      = 1'b0;
    bus.i_addr    = '0;
    bus.i_data    = '0;
    bus.rd_addr   = '0;
    for (int j = 0; j < N; j++) begin
      mv[j] = 16'hECE1;
      mi[j] = 16'h0000;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Reset state
    for (int a = 0; a < N; a++) check_rd("reset", a, 16'hECE1, 16'hF600);
    check("reset_busy", {31'h0, bus.busy}, 32'd0);
    check("reset_done", {31'h0, bus.done}, 32'd0);
    check("reset_spike", {31'h0, bus.spike_valid}, 32'd0);
    check("reset_dp_valid", {31'h0, bus.dp_valid}, 32'd0);
    check("reset_dp_v", {16'h0, bus.dp_v}, 32'd0);

    // Three steps, i[2]=0x0100: 2*4*3+1 = 25 busy cycles
    write_i(2, 16'h0100);
    run(3, 1'b0, 1'b0);
    check("run3_cycles", run_cycles, 25);
    check("run3_done_at", done_at, 25);
    check("run3_done_cnt", done_cnt, 1);
    check("run3_valid", run_valid, 12);
    check("run3_spikes", spk_n, 0);
    check_rd("run3", 0, 16'hECE1, 16'hF600);
    check_rd("run3", 1, 16'hECE1, 16'hF600);
    check_rd("run3", 2, 16'hEFE1, 16'hF600);
    check_rd("run3", 3, 16'hECE1, 16'hF600);

    // Five steps, i[1]=0x1000: v1 -4895,-799,3297,7393 -> single spike at step 2; ends at 15585
    write_i(1, 16'h1000);
    run(5, 1'b0, 1'b0);
    check("run5_cycles", run_cycles, 41);
    check("run5_spikes", spk_n, 1);
    check("run5_spike_idx", spk_idx, 1);
    check("run5_spike_step", spk_step, 2);
    check_rd("run5", 1, 16'h3CE1, 16'hF600);
    check_rd("run5", 2, 16'hF4E1, 16'hF600);
    check_rd("run5", 0, 16'hECE1, 16'hF600);

    // Zero steps: one busy cycle carrying done, no operands, array untouched
    run(0, 1'b0, 1'b0);
    check("run0_cycles", run_cycles, 1);
    check("run0_done_at", done_at, 1);
    check("run0_valid", run_valid, 0);
    check_rd("run0", 1, 16'hECE1 + 16'h5000, 16'hF600);
    check_rd("run0", 2, 16'hF4E1, 16'hF600);

    // Clear + one step: 4+8+1 = 13 cycles; mid-run start and i_we are dropped
    run(1, 1'b1, 1'b1);
    check("clr_cycles", run_cycles, 13);
    check("clr_done_at", done_at, 13);
    check("clr_valid", run_valid, 4);
    check_rd("clr", 0, 16'hECE1, 16'hF600);
    check_rd("clr", 1, 16'hFCE1, 16'hF600);
    check_rd("clr", 2, 16'hEDE1, 16'hF600);
    check_rd("clr", 3, 16'hECE1, 16'hF600);
    tick();
    check("clr_idle_after", {31'h0, bus.busy}, 32'd0);

    // Asynchronous reset during CAPTURE of step 1 (fifth operand pair)
    bus.start     = 1'b1;
    bus.clear     = 1'b0;
    bus.num_steps = 16'd3;
    tick();
    bus.start = 1'b0;
    nv = 0;
    for (int c = 0; c < 200 && nv < 5; c++) begin
      if (bus.dp_valid) nv++;
      if (nv < 5) tick();
    end
    check("rst_reached_capture", nv, 5);
    #2;
    rst = 1'b1;
    #1;
    check("rst_busy", {31'h0, bus.busy}, 32'd0);
    check("rst_spike", {31'h0, bus.spike_valid}, 32'd0);
    check("rst_dp_valid", {31'h0, bus.dp_valid}, 32'd0);
    for (int a = 0; a < N; a++) check_rd("rst", a, 16'hECE1, 16'hF600);
    @(negedge clk);
    rst = 1'b0;
    tick();
    for (int j = 0; j < N; j++) begin
      mv[j] = 16'hECE1;
      mi[j] = 16'h0000;
    end

    // Fresh run after reset: currents are zero so v stays at its initial value
    run(2, 1'b0, 1'b0);
    check("post_rst_cycles", run_cycles, 17);
    check("post_rst_done_at", done_at, 17);
    check("post_rst_spikes", spk_n, 0);
    for (int a = 0; a < N; a++) check_rd("post_rst", a, 16'hECE1, 16'hF600);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
